lag_scan_sequencer: RTL



---
 rtl/lag_scan_pkg.sv | 17 +
 rtl/lag_scan_sequencer_channel.sv | 173 +++++++++++++++++
 rtl/lag_scan_sequencer.sv | 83 ++++++++
 3 files changed

// File: rtl/lag_scan_pkg.sv
// Shared encodings for the lag-scan sequencer: scan modes and channel FSM states.
package lag_scan_pkg;

   typedef enum logic [1:0] {
      MODE_ONESHOT  = 2'd0,
      MODE_WRAP     = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_HOLD     = 2'd3
   } scan_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } scan_state_e;

endpackage

// File: rtl/lag_scan_sequencer_channel.sv
// One lag-scan channel: latches its configuration on run, then steps current on each
// shared dwell tick according to the latched mode.
module lag_scan_channel
   import lag_scan_pkg::*;
#(
   parameter int LAG_WIDTH   = 20,
   parameter int INC_WIDTH   = 12,
   parameter int SWEEP_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   tick,
   input  logic                   run,
   input  logic [LAG_WIDTH-1:0]   start_i,
   input  logic [LAG_WIDTH-1:0]   len_i,
   input  logic [INC_WIDTH-1:0]   inc_i,
   input  logic [1:0]             mode_i,
   output logic [LAG_WIDTH-1:0]   current_o,
   output logic                   step_pulse_o,
   output logic                   done_o,
   output logic [SWEEP_WIDTH-1:0] sweeps_o
);

   localparam logic [LAG_WIDTH:0]     LAG_MAX   = {1'b0, {LAG_WIDTH{1'b1}}};
   localparam logic [SWEEP_WIDTH-1:0] SWEEP_MAX = {SWEEP_WIDTH{1'b1}};
   localparam logic [SWEEP_WIDTH-1:0] SWEEP_ONE = {{(SWEEP_WIDTH-1){1'b0}}, 1'b1};

   scan_state_e            state_q, state_d;
   scan_mode_e             mode_q, mode_d;
   logic [LAG_WIDTH-1:0]   start_q, start_d;
   logic [LAG_WIDTH-1:0]   end_q, end_d;
   logic [LAG_WIDTH-1:0]   cur_q, cur_d;
   logic [INC_WIDTH-1:0]   inc_q, inc_d;
   logic [SWEEP_WIDTH-1:0] sweeps_q, sweeps_d;
   logic                   done_q, done_d;
   logic                   dir_down_q, dir_down_d;
   logic                   pulse_q, pulse_d;

   // All comparisons are one bit wider than a lag so start+len and current+inc never wrap.
   logic [LAG_WIDTH:0]     raw_end;
   logic [LAG_WIDTH:0]     clamped_end;
   logic [LAG_WIDTH:0]     inc_ext;
   logic [LAG_WIDTH:0]     cur_up;
   logic [LAG_WIDTH:0]     start_up;
   logic [LAG_WIDTH:0]     end_ext;
   logic [SWEEP_WIDTH-1:0] sweeps_inc;

   assign raw_end     = {1'b0, start_i} + {1'b0, len_i};
   assign clamped_end = (raw_end > LAG_MAX) ? LAG_MAX : raw_end;
   assign inc_ext     = {{(LAG_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_q};
   assign cur_up      = {1'b0, cur_q} + inc_ext;
   assign start_up    = {1'b0, start_q} + inc_ext;
   assign end_ext     = {1'b0, end_q};
   assign sweeps_inc  = (sweeps_q == SWEEP_MAX) ? sweeps_q : sweeps_q + SWEEP_ONE;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      start_d    = start_q;
      end_d      = end_q;
      cur_d      = cur_q;
      inc_d      = inc_q;
      sweeps_d   = sweeps_q;
      done_d     = done_q;
      dir_down_d = dir_down_q;
      pulse_d    = 1'b0;

      if (enable) begin
         if (!run) begin
            state_d    = ST_IDLE;
            cur_d      = start_i;
            done_d     = 1'b0;
            sweeps_d   = '0;
            dir_down_d = 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  start_d = start_i;
                  end_d   = clamped_end[LAG_WIDTH-1:0];
                  inc_d   = inc_i;
                  mode_d  = scan_mode_e'(mode_i);
                  cur_d   = start_i;
                  state_d = ST_SCAN;
               end
               ST_SCAN: begin
                  if (tick) begin
                     case (mode_q)
                        MODE_ONESHOT: begin
                           pulse_d = 1'b1;
                           if (cur_up >= end_ext) begin
                              cur_d   = end_q;
                              done_d  = 1'b1;
                              state_d = ST_DONE;
                           end else begin
                              cur_d = cur_up[LAG_WIDTH-1:0];
                           end
                        end
                        MODE_WRAP: begin
                           pulse_d = 1'b1;
                           if (cur_up > end_ext) begin
                              cur_d    = start_q;
                              sweeps_d = sweeps_inc;
                           end else begin
                              cur_d = cur_up[LAG_WIDTH-1:0];
                           end
                        end
                        MODE_PINGPONG: begin
                           pulse_d = 1'b1;
                           if (!dir_down_q) begin
                              if (cur_up >= end_ext) begin
                                 cur_d      = end_q;
                                 dir_down_d = 1'b1;
                              end else begin
                                 cur_d = cur_up[LAG_WIDTH-1:0];
                              end
                           end else if ({1'b0, cur_q} <= start_up) begin
                              cur_d      = start_q;
                              dir_down_d = 1'b0;
                              sweeps_d   = sweeps_inc;
                           end else begin
                              cur_d = cur_q - inc_ext[LAG_WIDTH-1:0];
                           end
                        end
                        default: begin
                           cur_d = start_q;
                        end
                     endcase
                  end
               end
               ST_DONE: begin
                  cur_d = end_q;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_ONESHOT;
         start_q    <= '0;
         end_q      <= '0;
         cur_q      <= '0;
         inc_q      <= '0;
         sweeps_q   <= '0;
         done_q     <= 1'b0;
         dir_down_q <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         start_q    <= start_d;
         end_q      <= end_d;
         cur_q      <= cur_d;
         inc_q      <= inc_d;
         sweeps_q   <= sweeps_d;
         done_q     <= done_d;
         dir_down_q <= dir_down_d;
         pulse_q    <= pulse_d;
      end
   end

   assign current_o    = cur_q;
   assign step_pulse_o = pulse_q;
   assign done_o       = done_q;
   assign sweeps_o     = sweeps_q;

endmodule

// File: rtl/lag_scan_sequencer.sv
// Lag-scan sequencer top: one shared dwell timer driving NUM_INPUTS independent
// scan channels, with flat configuration and status buses sliced per channel.
module lag_scan_sequencer
   import lag_scan_pkg::*;
#(
   parameter int NUM_INPUTS  = 8,
   parameter int LAG_WIDTH   = 20,
   parameter int INC_WIDTH   = 12,
   parameter int DWELL_WIDTH = 16,
   parameter int SWEEP_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic [NUM_INPUTS-1:0]             run,
   input  logic [NUM_INPUTS*LAG_WIDTH-1:0]   start_a,
   input  logic [NUM_INPUTS*LAG_WIDTH-1:0]   len_a,
   input  logic [NUM_INPUTS*INC_WIDTH-1:0]   increment_a,
   input  logic [NUM_INPUTS*2-1:0]           mode_a,
   input  logic [DWELL_WIDTH-1:0]            dwell,
   output logic [NUM_INPUTS*LAG_WIDTH-1:0]   current_a,
   output logic [NUM_INPUTS-1:0]             step_pulse,
   output logic [NUM_INPUTS-1:0]             done,
   output logic [NUM_INPUTS*SWEEP_WIDTH-1:0] sweeps_a
);

   localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

   logic [DWELL_WIDTH-1:0] dwell_eff;
   logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
   logic [DWELL_WIDTH-1:0] period_q, period_d;
   logic                   tick;

   // The period is re-sampled only at a wrap so a dwell change never truncates a step.
   assign dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;
   assign tick      = enable && (cnt_q == (period_q - DWELL_ONE));

   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      if (enable) begin
         if (tick) begin
            cnt_d    = '0;
            period_d = dwell_eff;
         end else begin
            cnt_d = cnt_q + DWELL_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         period_q <= dwell_eff;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

   for (genvar ch = 0; ch < NUM_INPUTS; ch++) begin : g_chan
      lag_scan_channel #(
         .LAG_WIDTH   (LAG_WIDTH),
         .INC_WIDTH   (INC_WIDTH),
         .SWEEP_WIDTH (SWEEP_WIDTH)
      ) u_chan (
         .clk          (clk),
         .reset        (reset),
         .enable       (enable),
         .tick         (tick),
         .run          (run[ch]),
         .start_i      (start_a[ch*LAG_WIDTH +: LAG_WIDTH]),
         .len_i        (len_a[ch*LAG_WIDTH +: LAG_WIDTH]),
         .inc_i        (increment_a[ch*INC_WIDTH +: INC_WIDTH]),
         .mode_i       (mode_a[ch*2 +: 2]),
         .current_o    (current_a[ch*LAG_WIDTH +: LAG_WIDTH]),
         .step_pulse_o (step_pulse[ch]),
         .done_o       (done[ch]),
         .sweeps_o     (sweeps_a[ch*SWEEP_WIDTH +: SWEEP_WIDTH])
      );
   end

endmodule
